// File: rtl/alu_issue_unit.sv
// Two-stage issue/result pipeline driving a combinational ALU.
// Stage 1 registers the operands onto the ALU; stage 2 captures the result for a downstream handshake.
module alu_issue_unit #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [31:0]      i_req_a,
  input  logic [31:0]      i_req_b,
  input  logic [3:0]       i_req_op,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic [31:0]      o_alu_a,
  output logic [31:0]      o_alu_b,
  output logic [3:0]       o_alu_op,
  input  logic [31:0]      i_alu_y,
  input  logic             i_alu_eq,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_y,
  output logic             o_rsp_eq,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic [CNT_W-1:0] o_done_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic s2_free, s1_adv, accept, rsp_hs;

  assign s2_free = !s2_valid_q || i_rsp_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  // Ready is forced low while reset is held so nothing is offered a handshake mid-reset.
  assign o_req_ready = i_rst_n && !i_flush && (!s1_valid_q || s2_free);
  assign accept      = i_req_valid && o_req_ready;
  assign rsp_hs      = s2_valid_q && i_rsp_ready && !i_flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    rsp_y_d    = rsp_y_q;
    rsp_eq_d   = rsp_eq_q;
    rsp_tag_d  = rsp_tag_q;
    done_cnt_d = done_cnt_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        alu_a_d    = i_req_a;
        alu_b_d    = i_req_b;
        alu_op_d   = i_req_op;
        s1_tag_d   = i_req_tag;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        rsp_y_d    = i_alu_y;
        rsp_eq_d   = i_alu_eq;
        rsp_tag_d  = s1_tag_q;
      end else if (rsp_hs) begin
        s2_valid_d = 1'b0;
      end
      if (rsp_hs) begin
        done_cnt_d = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      rsp_y_q    <= '0;
      rsp_eq_q   <= 1'b0;
      rsp_tag_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      rsp_y_q    <= rsp_y_d;
      rsp_eq_q   <= rsp_eq_d;
      rsp_tag_q  <= rsp_tag_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_rsp_valid = s2_valid_q;
  assign o_rsp_y     = rsp_y_q;
  assign o_rsp_eq    = rsp_eq_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit; a second instance with a 2-bit counter checks wrap-around.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_tag = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_eq, alu_eq;
  logic [31:0] alu_a, alu_b, alu_y, rsp_y;
  logic [3:0]  alu_op;
  logic [4:0]  rsp_tag;
  logic [15:0] done_cnt;

  logic        req_ready2, rsp_valid2, rsp_eq2, alu_eq2;
  logic [31:0] alu_a2, alu_b2, alu_y2, rsp_y2;
  logic [3:0]  alu_op2;
  logic [4:0]  rsp_tag2;
  logic [1:0]  done_cnt2;

  assign alu_y   = alu_a + alu_b;
  assign alu_eq  = (alu_a == alu_b);
  assign alu_y2  = alu_a2 + alu_b2;
  assign alu_eq2 = (alu_a2 == alu_b2);

  always #5 clk = ~clk;

  alu_issue_unit #(.TAG_W(5), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op), .i_req_tag(req_tag),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_y(alu_y), .i_alu_eq(alu_eq),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_y(rsp_y), .o_rsp_eq(rsp_eq), .o_rsp_tag(rsp_tag),
    .o_done_cnt(done_cnt)
  );

  alu_issue_unit #(.TAG_W(5), .CNT_W(2)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready2),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op), .i_req_tag(req_tag),
    .o_alu_a(alu_a2), .o_alu_b(alu_b2), .o_alu_op(alu_op2),
    .i_alu_y(alu_y2), .i_alu_eq(alu_eq2),
    .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready),
    .o_rsp_y(rsp_y2), .o_rsp_eq(rsp_eq2), .o_rsp_tag(rsp_tag2),
    .o_done_cnt(done_cnt2)
  );

  typedef struct {
    logic [31:0] y;
    logic        eq;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [4:0] tag);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    exp_t x;
    x.y   = a + b;
    x.eq  = (a == b);
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Fill both stages with the response side stalled, then reset mid-cycle.
    rsp_ready = 1'b0;
    @(negedge clk); drive(1'b1, 32'd3, 32'd4, 4'd1, 5'd1);
    @(negedge clk); drive(1'b1, 32'd9, 32'd9, 4'd2, 5'd2);
    @(negedge clk); drive(1'b0, '0, '0, '0, '0);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_prefill: rsp_valid=%0b required 1", rsp_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_op, rsp_y, rsp_eq, rsp_tag, done_cnt, rsp_valid, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%0h b=%0h op=%0h y=%0h eq=%0b tag=%0h cnt=%0h rv=%0b rr=%0b required all 0",
               alu_a, alu_b, alu_op, rsp_y, rsp_eq, rsp_tag, done_cnt, rsp_valid, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || done_cnt !== 16'd0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%0b cnt=%0d rv=%0b required 1/0/0", req_ready, done_cnt, rsp_valid);
    end
    sb.delete();
    $display("reset: mid-stream reset done");
  endtask

  task automatic test_single;
    rsp_ready = 1'b1;
    @(negedge clk); drive(1'b1, 32'd16, 32'd2, 4'd3, 5'd5);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %0b required 1", req_ready);
    end
    push_exp(32'd16, 32'd2, 5'd5);
    @(negedge clk); drive(1'b0, '0, '0, '0, '0);
    #1;
    n_checks++;
    if (alu_op !== 4'd3 || alu_a !== 32'd16 || alu_b !== 32'd2 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: op=%0d a=%0d b=%0d rv=%0b required 3/16/2/0", alu_op, alu_a, alu_b, rsp_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_rsp_valid: got %0b required 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_y !== e.y || rsp_eq !== e.eq || rsp_tag !== e.tag) begin
        n_fail++;
        $display("FAIL single_rsp: y=%0d eq=%0b tag=%0d required %0d/%0b/%0d", rsp_y, rsp_eq, rsp_tag, e.y, e.eq, e.tag);
      end
      $display("single: rsp tag=%0d y=%0d eq=%0b", rsp_tag, rsp_y, rsp_eq);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_cnt !== 16'd1) begin
      n_fail++; $display("FAIL single_cnt: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_streaming;
    int seen = 0;
    logic [15:0] cnt0;
    cnt0 = done_cnt;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 10) drive(1'b1, k, k, 4'd0, k[4:0]);
      else drive(1'b0, '0, '0, '0, '0);
      #1;
      if (k < 10) begin
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_ready: k=%0d got %0b required 1", k, req_ready);
        end
        push_exp(k, k, k[4:0]);
      end
      if (k >= 2) begin
        n_checks++;
        if (rsp_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_gap: cycle %0d rsp_valid=%0b required 1", k, rsp_valid);
        end
      end
      if (rsp_valid && rsp_ready) begin
        seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got tag=%0d required no response", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_y !== e.y || rsp_eq !== e.eq || rsp_tag !== e.tag) begin
            n_fail++;
            $display("FAIL stream_rsp: y=%0d eq=%0b tag=%0d required %0d/%0b/%0d", rsp_y, rsp_eq, rsp_tag, e.y, e.eq, e.tag);
          end
          $display("stream: rsp tag=%0d y=%0d eq=%0b", rsp_tag, rsp_y, rsp_eq);
        end
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (seen != 10 || done_cnt !== cnt0 + 16'd10) begin
      n_fail++; $display("FAIL stream_count: seen=%0d cnt=%0d required 10/%0d", seen, done_cnt, cnt0 + 16'd10);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ra [3];
    logic [31:0] rb [3];
    int idx = 0;
    int seen = 0;
    ra = '{32'd16, 32'd5, 32'd7};
    rb = '{32'd2, 32'd5, 32'd1};
    rsp_ready = 1'b0;
    for (int c = 0; c < 16 && seen < 3; c++) begin
      @(negedge clk);
      rsp_ready = (c >= 5);
      if (idx < 3) drive(1'b1, ra[idx], rb[idx], 4'd0, 5'(idx + 1));
      else drive(1'b0, '0, '0, '0, '0);
      #1;
      if (c >= 2 && c < 5) begin
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_y !== 32'd18) begin
          n_fail++;
          $display("FAIL bp_stall: c=%0d ready=%0b rv=%0b y=%0d required 0/1/18", c, req_ready, rsp_valid, rsp_y);
        end
      end
      if (c < 2 || c == 5) begin
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL bp_ready: c=%0d got %0b required 1", c, req_ready);
        end
      end
      if (req_valid && req_ready) begin
        push_exp(ra[idx], rb[idx], 5'(idx + 1));
        idx++;
      end
      if (rsp_valid && rsp_ready) begin
        seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: got tag=%0d required no response", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_y !== e.y || rsp_eq !== e.eq || rsp_tag !== e.tag) begin
            n_fail++;
            $display("FAIL bp_rsp: y=%0d eq=%0b tag=%0d required %0d/%0b/%0d", rsp_y, rsp_eq, rsp_tag, e.y, e.eq, e.tag);
          end
          $display("backpressure: rsp tag=%0d y=%0d eq=%0b", rsp_tag, rsp_y, rsp_eq);
        end
      end
    end
    n_checks++;
    if (seen != 3 || sb.size() != 0) begin
      n_fail++; $display("FAIL bp_loss: responses=%0d left=%0d required 3/0", seen, sb.size());
    end
    drive(1'b0, '0, '0, '0, '0);
  endtask

  task automatic test_flush;
    logic [15:0] cnt0;
    int got = 0;
    rsp_ready = 1'b0;
    @(negedge clk); drive(1'b1, 32'd1, 32'd1, 4'd0, 5'd10);
    @(negedge clk); drive(1'b1, 32'd2, 32'd3, 4'd0, 5'd11);
    @(negedge clk);
    drive(1'b1, 32'd4, 32'd4, 4'd0, 5'd12);
    flush = 1'b1;
    rsp_ready = 1'b1;
    #1;
    cnt0 = done_cnt;
    n_checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: ready=%0b rv=%0b required 0/1", req_ready, rsp_valid);
    end
    sb.delete();
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || done_cnt !== cnt0) begin
      n_fail++; $display("FAIL flush_drop: rv=%0b cnt=%0d required 0/%0d", rsp_valid, done_cnt, cnt0);
    end
    @(negedge clk); drive(1'b1, 32'd100, 32'd23, 4'd7, 5'd13);
    #1;
    if (req_ready) push_exp(32'd100, 32'd23, 5'd13);
    for (int c = 0; c < 6 && got == 0; c++) begin
      @(negedge clk); drive(1'b0, '0, '0, '0, '0);
      #1;
      if (rsp_valid && rsp_ready) begin
        got = 1;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL flush_extra: got tag=%0d required no response", rsp_tag);
        end else begin
          e = sb.pop_front();
          if (rsp_y !== e.y || rsp_eq !== e.eq || rsp_tag !== e.tag) begin
            n_fail++;
            $display("FAIL flush_after: y=%0d eq=%0b tag=%0d required %0d/%0b/%0d", rsp_y, rsp_eq, rsp_tag, e.y, e.eq, e.tag);
          end
          $display("flush: rsp tag=%0d y=%0d eq=%0b", rsp_tag, rsp_y, rsp_eq);
        end
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (got != 1 || done_cnt !== cnt0 + 16'd1) begin
      n_fail++; $display("FAIL flush_resume: got=%0d cnt=%0d required 1/%0d", got, done_cnt, cnt0 + 16'd1);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] wrap_exp [5];
    int idx = 0;
    int issued = 0;
    logic hs_prev = 1'b0;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      @(negedge clk);
      if (issued < 5) drive(1'b1, issued, 32'd1, 4'd0, 5'(issued));
      else drive(1'b0, '0, '0, '0, '0);
      #1;
      if (hs_prev) begin
        n_checks++;
        if (done_cnt2 !== wrap_exp[idx]) begin
          n_fail++; $display("FAIL wrap_cnt: step %0d got %0d required %0d", idx, done_cnt2, wrap_exp[idx]);
        end
        $display("wrap: completion %0d cnt=%0d", idx + 1, done_cnt2);
        idx++;
      end
      if (req_valid && req_ready2) issued++;
      hs_prev = rsp_valid2 && rsp_ready;
    end
    n_checks++;
    if (idx != 5) begin
      n_fail++; $display("FAIL wrap_timeout: completions=%0d required 5", idx);
    end
    drive(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
